// File: rtl/axi_riscv_amos_rmw_ctrl.sv
// axi_riscv_amos_rmw_ctrl
// Read-modify-write sequencer for the AXI RISC-V atomics adapter. One atomic
// request at a time: read the target word, run it through the AMO ALU
// together with the request operand, write the result back, and return the
// old value and error status to the requester.
//
// Optional feature macro: AMOS_SKIP_SILENT_WRITE_EN
//   When defined, a write-back whose data equals the value just read is
//   skipped and the sequencer goes straight from RD_WAIT to RESP.
//
// XAMO codes are local copies of the extended-op encodings used by the
// decode stage. They are selected when the ATOP code is ATOP_NONE (op[5:4]=0).

module axi_riscv_amos_rmw_ctrl #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    // atomic request
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [5:0]            req_op_i,
    input  logic [5:0]            req_xop_i,
    input  logic [DATA_WIDTH-1:0] req_operand_i,
    input  logic [ID_WIDTH-1:0]   req_id_i,
    // memory read request
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    // memory read data
    input  logic                  rd_rsp_valid_i,
    output logic                  rd_rsp_ready_o,
    input  logic [DATA_WIDTH-1:0] rd_rsp_data_i,
    input  logic                  rd_rsp_err_i,
    // memory write request
    output logic                  wr_valid_o,
    input  logic                  wr_ready_i,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    // memory write acknowledge
    input  logic                  wr_rsp_valid_i,
    output logic                  wr_rsp_ready_o,
    input  logic                  wr_rsp_err_i,
    // completion
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] resp_data_o,
    output logic [ID_WIDTH-1:0]   resp_id_o,
    output logic                  resp_err_o,
    output logic                  busy_o
);

    localparam logic [5:0] XAMO_INC = 6'd1;
    localparam logic [5:0] XAMO_DEC = 6'd2;
    localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        RESP
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [5:0]            op_q;
    logic [5:0]            xop_q;
    logic [DATA_WIDTH-1:0] operand_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [DATA_WIDTH-1:0] old_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  err_q;

    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  skip_write;

    // AMO ALU. op[3] (endianness) is a don't-care: words are handled as-is.
    // Compare-and-swap has no compare value on this port, so it leaves the
    // word unchanged.
    function automatic logic [DATA_WIDTH-1:0] amo_alu(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b,
        input logic [5:0]            op,
        input logic [5:0]            xop
    );
        logic [DATA_WIDTH-1:0] res;
        res = a;
        casez (op)
            6'b01?000, 6'b10?000: res = a + b;
            6'b01?001, 6'b10?001: res = a & ~b;
            6'b01?010, 6'b10?010: res = a ^ b;
            6'b01?011, 6'b10?011: res = a | b;
            6'b01?100, 6'b10?100: res = ($signed(a) > $signed(b)) ? a : b;
            6'b01?101, 6'b10?101: res = ($signed(a) < $signed(b)) ? a : b;
            6'b01?110, 6'b10?110: res = (a > b) ? a : b;
            6'b01?111, 6'b10?111: res = (a < b) ? a : b;
            6'b110000:            res = b;
            6'b00????: begin
                case (xop)
                    XAMO_INC: res = a + ONE;
                    XAMO_DEC: res = a - ONE;
                    default:  res = a;
                endcase
            end
            default:              res = a;
        endcase
        return res;
    endfunction

    // The read data bypasses old_q in RD_WAIT so the result is ready on the
    // same edge that captures the old value.
    assign alu_a      = (state_q == RD_WAIT) ? rd_rsp_data_i : old_q;
    assign alu_result = amo_alu(alu_a, operand_q, op_q, xop_q);

`ifdef AMOS_SKIP_SILENT_WRITE_EN
    assign skip_write = (alu_result == rd_rsp_data_i);
`else
    assign skip_write = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process evaluation order.
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves
        // state_d unassigned, which would infer a latch.
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid_i)  state_d = RD_REQ;
            RD_REQ:  if (rd_ready_i)   state_d = RD_WAIT;
            RD_WAIT: begin
                if (rd_rsp_valid_i) begin
                    if (rd_rsp_err_i || skip_write) begin
                        state_d = RESP;
                    end else begin
                        state_d = WR_REQ;
                    end
                end
            end
            WR_REQ:  if (wr_ready_i)     state_d = WR_WAIT;
            WR_WAIT: if (wr_rsp_valid_i) state_d = RESP;
            RESP:    if (resp_ready_i)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture, read data / ALU result capture and error accumulation
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: the datapath registers are reset too, because they drive the
        // data/addr/id outputs directly and those must read 0 out of reset.
        if (!rst_ni) begin
            addr_q    <= '0;
            op_q      <= '0;
            xop_q     <= '0;
            operand_q <= '0;
            id_q      <= '0;
            old_q     <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        addr_q    <= req_addr_i;
                        op_q      <= req_op_i;
                        xop_q     <= req_xop_i;
                        operand_q <= req_operand_i;
                        id_q      <= req_id_i;
                        err_q     <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (rd_rsp_valid_i) begin
                        old_q   <= rd_rsp_data_i;
                        wdata_q <= alu_result;
                        err_q   <= rd_rsp_err_i;
                    end
                end
                WR_WAIT: begin
                    if (wr_rsp_valid_i) begin
                        err_q <= err_q | wr_rsp_err_i;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode from registered state only
    always_comb begin
        req_ready_o    = (state_q == IDLE);
        rd_valid_o     = (state_q == RD_REQ);
        rd_rsp_ready_o = (state_q == RD_WAIT);
        wr_valid_o     = (state_q == WR_REQ);
        wr_rsp_ready_o = (state_q == WR_WAIT);
        resp_valid_o   = (state_q == RESP);
        busy_o         = (state_q != IDLE);
        rd_addr_o      = addr_q;
        wr_addr_o      = addr_q;
        wr_data_o      = wdata_q;
        // Atomic stores return no data.
        resp_data_o    = (op_q[5:4] == 2'b01) ? '0 : old_q;
        resp_id_o      = id_q;
        resp_err_o     = err_q;
    end

endmodule

// File: tb/tb_axi_riscv_amos_rmw_ctrl.sv
// Self-checking bench for axi_riscv_amos_rmw_ctrl. A peer model plays the
// memory (read/write channels) and the requester's response side; expected
// writes and responses are queued when a request is driven and compared
// when the DUT presents them.

module tb_axi_riscv_amos_rmw_ctrl;

    localparam int DW = 64;
    localparam int AW = 64;
    localparam int IW = 4;
    localparam logic [5:0] XAMO_INC = 6'd1;
    localparam logic [63:0] ALL1 = {64{1'b1}};

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [AW-1:0] req_addr_i;
    logic [5:0]    req_op_i;
    logic [5:0]    req_xop_i;
    logic [DW-1:0] req_operand_i;
    logic [IW-1:0] req_id_i;
    logic          rd_valid_o;
    logic          rd_ready_i;
    logic [AW-1:0] rd_addr_o;
    logic          rd_rsp_valid_i;
    logic          rd_rsp_ready_o;
    logic [DW-1:0] rd_rsp_data_i;
    logic          rd_rsp_err_i;
    logic          wr_valid_o;
    logic          wr_ready_i;
    logic [AW-1:0] wr_addr_o;
    logic [DW-1:0] wr_data_o;
    logic          wr_rsp_valid_i;
    logic          wr_rsp_ready_o;
    logic          wr_rsp_err_i;
    logic          resp_valid_o;
    logic          resp_ready_i;
    logic [DW-1:0] resp_data_o;
    logic [IW-1:0] resp_id_o;
    logic          resp_err_o;
    logic          busy_o;

    axi_riscv_amos_rmw_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .ID_WIDTH  (IW)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_addr_i    (req_addr_i),
        .req_op_i      (req_op_i),
        .req_xop_i     (req_xop_i),
        .req_operand_i (req_operand_i),
        .req_id_i      (req_id_i),
        .rd_valid_o    (rd_valid_o),
        .rd_ready_i    (rd_ready_i),
        .rd_addr_o     (rd_addr_o),
        .rd_rsp_valid_i(rd_rsp_valid_i),
        .rd_rsp_ready_o(rd_rsp_ready_o),
        .rd_rsp_data_i (rd_rsp_data_i),
        .rd_rsp_err_i  (rd_rsp_err_i),
        .wr_valid_o    (wr_valid_o),
        .wr_ready_i    (wr_ready_i),
        .wr_addr_o     (wr_addr_o),
        .wr_data_o     (wr_data_o),
        .wr_rsp_valid_i(wr_rsp_valid_i),
        .wr_rsp_ready_o(wr_rsp_ready_o),
        .wr_rsp_err_i  (wr_rsp_err_i),
        .resp_valid_o  (resp_valid_o),
        .resp_ready_i  (resp_ready_i),
        .resp_data_o   (resp_data_o),
        .resp_id_o     (resp_id_o),
        .resp_err_o    (resp_err_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [DW-1:0] data;
        logic [IW-1:0] id;
        logic          err;
        int            lat;
    } resp_exp_t;

    resp_exp_t     resp_q[$];
    logic [DW-1:0] wr_q[$];

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            n_done = 0;
    int            accept_cyc = 0;
    logic [DW-1:0] mem_word = '0;
    logic [AW-1:0] cur_addr = '0;
    logic          rd_err_sel = 1'b0;
    logic          wr_err_sel = 1'b0;
    int            rd_stall = 0;
    int            wr_stall = 0;
    int            wrsp_stall = 0;
    int            resp_stall = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // Peer model: drives ready/valid inputs on the falling edge and checks
    // whatever the DUT presents; the handshakes it sets up complete on the
    // next rising edge.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            rd_ready_i     = 1'b1;
            rd_rsp_valid_i = 1'b0;
            rd_rsp_data_i  = '0;
            rd_rsp_err_i   = 1'b0;
            wr_ready_i     = 1'b1;
            wr_rsp_valid_i = 1'b0;
            wr_rsp_err_i   = 1'b0;
            resp_ready_i   = 1'b1;
        end else begin
            // read request, address checked every cycle it is presented
            if (rd_valid_o) begin
                check("rd_addr", rd_addr_o, cur_addr);
                if (rd_stall > 0) begin
                    rd_ready_i = 1'b0;
                    rd_stall--;
                end else begin
                    rd_ready_i = 1'b1;
                end
            end else begin
                rd_ready_i = 1'b1;
            end
            // read data
            rd_rsp_valid_i = rd_rsp_ready_o;
            rd_rsp_data_i  = rd_rsp_ready_o ? mem_word : '0;
            rd_rsp_err_i   = rd_rsp_ready_o & rd_err_sel;
            // write request
            if (wr_valid_o) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_wr", 64'(wr_valid_o), 64'd0);
                    wr_ready_i = 1'b1;
                end else begin
                    check("wr_data", wr_data_o, wr_q[0]);
                    check("wr_addr", wr_addr_o, cur_addr);
                    if (wr_stall > 0) begin
                        wr_ready_i = 1'b0;
                        wr_stall--;
                    end else begin
                        wr_ready_i = 1'b1;
                        mem_word   = wr_data_o;
                        void'(wr_q.pop_front());
                    end
                end
            end else begin
                wr_ready_i = 1'b1;
            end
            // write acknowledge
            if (wr_rsp_ready_o) begin
                if (wrsp_stall > 0) begin
                    wr_rsp_valid_i = 1'b0;
                    wrsp_stall--;
                end else begin
                    wr_rsp_valid_i = 1'b1;
                end
                wr_rsp_err_i = wr_err_sel;
            end else begin
                wr_rsp_valid_i = 1'b0;
                wr_rsp_err_i   = 1'b0;
            end
            // completion
            if (resp_valid_o) begin
                if (resp_q.size() == 0) begin
                    check("unexpected_resp", 64'(resp_valid_o), 64'd0);
                    resp_ready_i = 1'b1;
                end else begin
                    check("resp_data", resp_data_o, resp_q[0].data);
                    check("resp_id", 64'(resp_id_o), 64'(resp_q[0].id));
                    check("resp_err", 64'(resp_err_o), 64'(resp_q[0].err));
                    if (resp_stall > 0) begin
                        resp_ready_i = 1'b0;
                        resp_stall--;
                    end else begin
                        resp_ready_i = 1'b1;
                        check("latency", 64'(cyc - accept_cyc), 64'(resp_q[0].lat));
                        void'(resp_q.pop_front());
                        n_done++;
                    end
                end
            end else begin
                resp_ready_i = 1'b1;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready_o), 64'd1);
        check({tag, "_rd_valid"}, 64'(rd_valid_o), 64'd0);
        check({tag, "_rd_rsp_ready"}, 64'(rd_rsp_ready_o), 64'd0);
        check({tag, "_wr_valid"}, 64'(wr_valid_o), 64'd0);
        check({tag, "_wr_rsp_ready"}, 64'(wr_rsp_ready_o), 64'd0);
        check({tag, "_resp_valid"}, 64'(resp_valid_o), 64'd0);
        check({tag, "_busy"}, 64'(busy_o), 64'd0);
        check({tag, "_rd_addr"}, rd_addr_o, 64'd0);
        check({tag, "_wr_addr"}, wr_addr_o, 64'd0);
        check({tag, "_wr_data"}, wr_data_o, 64'd0);
        check({tag, "_resp_data"}, resp_data_o, 64'd0);
        check({tag, "_resp_id"}, 64'(resp_id_o), 64'd0);
        check({tag, "_resp_err"}, 64'(resp_err_o), 64'd0);
    endtask

    // Drive one request, queue its expectations and wait for completion.
    task automatic run_txn(input string name, input logic [5:0] op, input logic [5:0] xop,
                           input logic [63:0] mem, input logic [63:0] b, input logic [3:0] id,
                           input logic rerr, input logic werr, input bit exp_wr,
                           input logic [63:0] exp_wd, input logic [63:0] exp_rd,
                           input logic exp_err, input int lat,
                           input int rs, input int ws, input int ps);
        int start;
        @(negedge clk_i);
        #1;
        mem_word   = mem;
        rd_err_sel = rerr;
        wr_err_sel = werr;
        rd_stall   = rs;
        wr_stall   = ws;
        resp_stall = ps;
        cur_addr   = 64'h1000 + 64'(id) * 64'd8;
        if (exp_wr) wr_q.push_back(exp_wd);
        resp_q.push_back('{data: exp_rd, id: id, err: exp_err, lat: lat});
        req_addr_i    = cur_addr;
        req_op_i      = op;
        req_xop_i     = xop;
        req_operand_i = b;
        req_id_i      = id;
        req_valid_i   = 1'b1;
        check({name, "_req_ready"}, 64'(req_ready_o), 64'd1);
        accept_cyc = cyc;
        start      = n_done;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        check({name, "_busy"}, 64'(busy_o), 64'd1);
        for (int i = 0; i < 100 && n_done == start; i++) @(negedge clk_i);
        check({name, "_done"}, 64'(n_done), 64'(start + 1));
        @(negedge clk_i);
        #1;
        check({name, "_idle"}, 64'(busy_o), 64'd0);
        check({name, "_wr_pending"}, 64'(wr_q.size()), 64'd0);
    endtask

    initial begin
        rst_ni        = 1'b0;
        req_valid_i   = 1'b0;
        req_addr_i    = '0;
        req_op_i      = '0;
        req_xop_i     = '0;
        req_operand_i = '0;
        req_id_i      = '0;
        repeat (3) @(negedge clk_i);
        #1;
        check_reset_outputs("reset");
        rst_ni = 1'b1;

        run_txn("add",    6'b100000, 6'd0, 64'd5, 64'd3, 4'd2, 1'b0, 1'b0,
                1'b1, 64'd8, 64'd5, 1'b0, 5, 0, 0, 0);
        run_txn("swap",   6'b110000, 6'd0, 64'hAA, 64'h55, 4'd3, 1'b0, 1'b0,
                1'b1, 64'h55, 64'hAA, 1'b0, 5, 0, 0, 0);
`ifdef AMOS_SKIP_SILENT_WRITE_EN
        run_txn("smin_st", 6'b010101, 6'd0, ALL1, 64'd4, 4'd4, 1'b0, 1'b0,
                1'b0, 64'd0, 64'd0, 1'b0, 3, 0, 0, 0);
`else
        run_txn("smin_st", 6'b010101, 6'd0, ALL1, 64'd4, 4'd4, 1'b0, 1'b0,
                1'b1, ALL1, 64'd0, 1'b0, 5, 0, 0, 0);
`endif
        run_txn("rd_err", 6'b100000, 6'd0, 64'd7, 64'd1, 4'd5, 1'b1, 1'b0,
                1'b0, 64'd0, 64'd7, 1'b1, 3, 0, 0, 0);
        run_txn("stall",  6'b100000, 6'd0, 64'd10, 64'd20, 4'd6, 1'b0, 1'b0,
                1'b1, 64'd30, 64'd10, 1'b0, 14, 3, 3, 3);
        run_txn("xinc",   6'b000000, XAMO_INC, ALL1, 64'd0, 4'd7, 1'b0, 1'b0,
                1'b1, 64'd0, ALL1, 1'b0, 5, 0, 0, 0);
        run_txn("wr_err", 6'b100011, 6'd0, 64'hF0, 64'h0F, 4'd8, 1'b0, 1'b1,
                1'b1, 64'hFF, 64'hF0, 1'b1, 5, 0, 0, 0);
        run_txn("umax",   6'b100110, 6'd0, 64'd3, 64'd9, 4'd9, 1'b0, 1'b0,
                1'b1, 64'd9, 64'd3, 1'b0, 5, 0, 0, 0);

        // Reset while waiting for the write acknowledge: no response expected.
        @(negedge clk_i);
        #1;
        mem_word      = 64'd5;
        rd_err_sel    = 1'b0;
        wr_err_sel    = 1'b0;
        wrsp_stall    = 20;
        cur_addr      = 64'h2000;
        wr_q.push_back(64'd8);
        req_addr_i    = cur_addr;
        req_op_i      = 6'b100000;
        req_xop_i     = 6'd0;
        req_operand_i = 64'd3;
        req_id_i      = 4'd11;
        req_valid_i   = 1'b1;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        for (int i = 0; i < 50 && !wr_rsp_ready_o; i++) @(negedge clk_i);
        check("rst_reach_wr_wait", 64'(wr_rsp_ready_o), 64'd1);
        #1;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("midrst");
        wrsp_stall = 0;
        wr_q.delete();
        resp_q.delete();
        repeat (2) @(negedge clk_i);
        #1;
        rst_ni = 1'b1;

        run_txn("post_rst", 6'b100000, 6'd0, 64'd100, 64'd1, 4'd12, 1'b0, 1'b0,
                1'b1, 64'd101, 64'd100, 1'b0, 5, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
